mux_rr_n_to_1: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshake and a one-entry registered output stage.
- Two modes:
  - Select mode: explicit select, as in the existing 4:1 mux.
  - Round-robin mode: fair arbitration among valid channels.
- Sits between several producer channels and one consumer, such as the display/LED path or a shared datapath input in the lab designs.

---
 rtl/mux_rr_n_to_1_pkg.sv | 12 +
 rtl/rr_arbiter_n.sv | 39 +++
 rtl/mux_rr_n_to_1.sv | 100 ++++++++++
 tb/tb_mux_rr_n_to_1.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_n_to_1_pkg.sv
// Shared definitions for the N:1 valid/ready multiplexer.
// Latency: none (constants only).
// Backpressure: not applicable.
//
// Contents: mode encodings used by the mux top level.
package mux_rr_n_to_1_pkg;

  // Mode encoding for mode_i.
  localparam logic MODE_SEL = 1'b0;  // explicit channel select
  localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Latency: purely combinational, no state.
// Backpressure: none; the caller qualifies the grant with its own load enable.
//
// Ports:
//   req   - N-bit request vector
//   ptr   - SW-bit starting search position (always < N)
//   grant - N-bit one-hot grant, zero when no request
//   idx   - SW-bit index of the granted channel, zero when no request
module rr_arbiter_n #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);

  // Walk the search order backwards so the last hit written is the one
  // closest to ptr. The wrap uses N, so non-power-of-two N never visits
  // channel indices that do not exist.
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = SW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_n_to_1.sv
// N-channel, W-bit valid/ready multiplexer, explicit-select or round-robin.
// Latency: one cycle; a word accepted at an edge is on q_o from that edge.
// Backpressure: when the held word is not taken, all ready_o drop; the
//   output register refills on the same edge it drains (one word per cycle).
//
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   mode_i            - MODE_SEL (0) or MODE_RR (1)
//   sel_i             - channel index in select mode (>= N means no grant)
//   data_i, valid_i   - packed channel data (channel k at [k*W +: W]), valids
//   ready_o           - per-channel ready, combinational
//   q_o, q_sel_o      - held word and the channel it came from
//   q_valid_o         - output register holds a word
//   q_ready_i         - consumer takes the held word
module mux_rr_n_to_1
  import mux_rr_n_to_1_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           mode_i,
  input  logic [SW-1:0]  sel_i,
  input  logic [N*W-1:0] data_i,
  input  logic [N-1:0]   valid_i,
  output logic [N-1:0]   ready_o,
  output logic [W-1:0]   q_o,
  output logic [SW-1:0]  q_sel_o,
  output logic           q_valid_o,
  input  logic           q_ready_i
);

  logic [SW-1:0] ptr;
  logic [N-1:0]  rr_grant;
  logic [SW-1:0] rr_idx;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_dat;
  logic          load_en;
  logic          xfer;

  rr_arbiter_n #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req   (valid_i),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Grant selection. The select-mode compare is done per channel against
  // an integer index so an out-of-range sel_i simply matches nothing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_dat = '0;
    if (mode_i == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant_idx = sel_i;
      for (int k = 0; k < N; k++) begin
        if (int'(sel_i) == k && valid_i[k]) grant[k] = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (grant[k]) grant_dat = data_i[k*W +: W];
    end
  end

  // The register can take a word when empty or when its word leaves now.
  assign load_en = !q_valid_o || q_ready_i;
  assign ready_o = (load_en && !rst_i) ? grant : '0;
  // A grant implies the channel is valid, so any ready bit is a transfer.
  assign xfer    = |ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o       <= '0;
      q_sel_o   <= '0;
      q_valid_o <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      q_o       <= grant_dat;
      q_sel_o   <= grant_idx;
      q_valid_o <= 1'b1;
      // Only round-robin transfers advance the pointer; select mode leaves
      // it where it was so arbitration resumes fairly after a mode switch.
      if (mode_i == MODE_RR) begin
        ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
      end
    end else if (q_ready_i && q_valid_o) begin
      q_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_n_to_1.sv
// Bench for mux_rr_n_to_1: a default (N=4) and a non-power-of-two (N=3)
// instance share stimulus and are both compared every cycle against a
// transaction-level model of the channel selection rules.
module tb_mux_rr_n_to_1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mode_i;
  logic [1:0]  sel_i;
  logic [31:0] data_i;
  logic [3:0]  valid_i;
  logic        q_ready_i;

  logic [3:0]  ready4;
  logic [7:0]  q4;
  logic [1:0]  qsel4;
  logic        qvld4;
  logic [2:0]  ready3;
  logic [7:0]  q3;
  logic [1:0]  qsel3;
  logic        qvld3;

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 = N=4 instance, index 1 = N=3 instance.
  int m_ptr [2];
  int m_q   [2];
  int m_sel [2];
  int m_vld [2];

  always #5 clk_i = ~clk_i;

  mux_rr_n_to_1 #(.N(4), .W(8)) dut4 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mode_i    (mode_i),
    .sel_i     (sel_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready4),
    .q_o       (q4),
    .q_sel_o   (qsel4),
    .q_valid_o (qvld4),
    .q_ready_i (q_ready_i)
  );

  mux_rr_n_to_1 #(.N(3), .W(8)) dut3 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mode_i    (mode_i),
    .sel_i     (sel_i),
    .data_i    (data_i[23:0]),
    .valid_i   (valid_i[2:0]),
    .ready_o   (ready3),
    .q_o       (q3),
    .q_sel_o   (qsel3),
    .q_valid_o (qvld3),
    .q_ready_i (q_ready_i)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int n_of(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  // Channel the spec rules pick this cycle, or -1 for no grant.
  function automatic int model_grant(input int u);
    int n;
    int c;
    n = n_of(u);
    if (mode_i == 1'b0) begin
      if (int'(sel_i) < n && valid_i[sel_i]) return int'(sel_i);
      return -1;
    end
    for (int i = 0; i < n; i++) begin
      c = (m_ptr[u] + i) % n;
      if (valid_i[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: inputs were set by the caller; check combinational
  // ready, advance the model across the edge, then check the register.
  task automatic step();
    int g [2];
    int acc [2];
    int exp_rdy;
    int n;
    #1;
    for (int u = 0; u < 2; u++) begin
      g[u]   = model_grant(u);
      acc[u] = (!rst_i && (m_vld[u] == 0 || q_ready_i) && g[u] >= 0) ? 1 : 0;
      exp_rdy = acc[u] ? (1 << g[u]) : 0;
      check($sformatf("n%0d_ready", n_of(u)),
            (u == 0) ? int'(ready4) : int'(ready3), exp_rdy);
    end
    @(posedge clk_i);
    for (int u = 0; u < 2; u++) begin
      n = n_of(u);
      if (rst_i) begin
        m_q[u] = 0; m_sel[u] = 0; m_vld[u] = 0; m_ptr[u] = 0;
      end else if (acc[u] == 1) begin
        m_q[u]   = int'((data_i >> (8 * g[u])) & 32'hFF);
        m_sel[u] = g[u];
        m_vld[u] = 1;
        if (mode_i == 1'b1) m_ptr[u] = (g[u] + 1) % n;
      end else if (q_ready_i && m_vld[u] == 1) begin
        m_vld[u] = 0;
      end
    end
    #1;
    check("n4_q",     int'(q4),    m_q[0]);
    check("n4_qsel",  int'(qsel4), m_sel[0]);
    check("n4_qvld",  int'(qvld4), m_vld[0]);
    check("n3_q",     int'(q3),    m_q[1]);
    check("n3_qsel",  int'(qsel3), m_sel[1]);
    check("n3_qvld",  int'(qvld3), m_vld[1]);
  endtask

  initial begin
    int exp_seq4 [6];
    int exp_seq3 [6];
    int held;
    exp_seq4 = '{0, 1, 2, 3, 0, 1};
    exp_seq3 = '{0, 1, 2, 0, 1, 2};

    // Reset.
    rst_i = 1'b1; mode_i = 1'b1; sel_i = 2'd0; data_i = '0;
    valid_i = 4'b0000; q_ready_i = 1'b1;
    step();
    rst_i = 1'b0;

    // Reset mid-transfer: load A5 from channel 2, then reset for a cycle.
    data_i = 32'h00A5_0000; valid_i = 4'b0100;
    step();
    check("load_a5", int'(q4), 8'hA5);
    rst_i = 1'b1; valid_i = 4'b1111;
    step();
    check("rst_qvld", int'(qvld4), 0);
    rst_i = 1'b0;

    // Out-of-range select: N=3 instance must not take anything.
    mode_i = 1'b0; sel_i = 2'd3; data_i = 32'h4433_2211;
    step();
    step();
    check("oor_n3_qvld", int'(qvld3), 0);

    // Round-robin fairness from ptr=0 (select mode left ptr untouched).
    mode_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rr4_seq%0d", i), int'(qsel4), exp_seq4[i]);
      check($sformatf("rr3_seq%0d", i), int'(qsel3), exp_seq3[i]);
    end

    // Select mode with default data.
    mode_i = 1'b0;
    sel_i = 2'd2; step(); check("sel2", int'(q4), 8'h33);
    sel_i = 2'd0; step(); check("sel0", int'(q4), 8'h11);
    sel_i = 2'd1; step(); check("sel1", int'(q4), 8'h22);
    sel_i = 2'd3; step(); check("sel3", int'(q4), 8'h44);

    // Sparse round-robin with wrap: put ptr at 1 via channel 0, then 1001.
    mode_i = 1'b1; valid_i = 4'b0001;
    step();
    valid_i = 4'b1001;
    step(); check("sparse_a", int'(qsel4), 3);
    step(); check("sparse_b", int'(qsel4), 0);

    // Backpressure, then drain and refill on the same edge.
    valid_i = 4'b1111; q_ready_i = 1'b0;
    held = int'(q4);
    for (int i = 0; i < 3; i++) begin
      data_i = $urandom;
      step();
      check("bp_hold", int'(q4), held);
    end
    q_ready_i = 1'b1;
    step(); check("refill_vld", int'(qvld4), 1);
    step(); check("refill_vld2", int'(qvld4), 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rst_i     = ($urandom_range(0, 49) == 0);
      mode_i    = 1'($urandom);
      sel_i     = 2'($urandom);
      data_i    = $urandom;
      valid_i   = 4'($urandom);
      q_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
